bist_sig_checker: RTL and testbench

- Response-analysis stage directly downstream of the BIST pattern source.
- Consumes the source's 32-bit data stream, its valid strobe and its frame sync.
- Compacts each frame of FRAME_LEN words into a MISR signature and compares it with an expected signature.
- Reports pass/fail/timeout per frame and keeps saturating frame tallies for the test controller.

---
 rtl/bist_pkg.sv | 17 +
 rtl/bist_sig_checker_if.sv | 20 ++
 rtl/bist_misr.sv | 23 ++
 rtl/bist_sig_checker.sv | 75 +++++++
 tb/tb_bist_sig_checker.sv | 136 +++++++++++++
 5 files changed

// File: rtl/bist_pkg.sv
// bist_pkg: shared state type, default parameters and MISR step for BIST response analysis
package bist_pkg;
   typedef enum logic [1:0] {IDLE, COLLECT, REPORT} state_t;
   localparam int          DEF_DATA_WIDTH = 32;
   localparam int          DEF_FRAME_LEN  = 16;
   localparam logic [31:0] DEF_MISR_POLY  = 32'h04C11DB7;
   localparam logic [31:0] DEF_MISR_SEED  = 32'hFFFFFFFF;
   localparam int          DEF_TIMEOUT    = 64;
   localparam int          MAX_W          = 64;
   typedef logic [MAX_W-1:0] wide_t;
   // Galois left-shift step of width w, computed in a wide container and masked back to w bits
   function automatic wide_t misr_step(input wide_t m, input wide_t d, input wide_t poly, input int w);
      wide_t mask;
      mask = (w >= MAX_W) ? '1 : (wide_t'(1) << w) - wide_t'(1);
      return (((m << 1) ^ (m[w-1] ? poly : '0)) ^ d) & mask;
   endfunction
endpackage

// File: rtl/bist_sig_checker_if.sv
// bist_sig_checker_if: pattern-source stream in, per-frame verdict and tallies out
// master: drives in_data/in_valid/in_sync/exp_sig, observes results
// slave : the checker; consumes the stream and drives busy/done/pass/timeout/signature/frames_*
interface bist_sig_checker_if #(parameter int DATA_WIDTH = 32);
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_valid;
   logic                  in_sync;
   logic [DATA_WIDTH-1:0] exp_sig;
   logic                  busy;
   logic                  done;
   logic                  pass;
   logic                  timeout;
   logic [DATA_WIDTH-1:0] signature;
   logic [15:0]           frames_ok;
   logic [15:0]           frames_fail;
   modport master (output in_data, in_valid, in_sync, exp_sig,
                   input  busy, done, pass, timeout, signature, frames_ok, frames_fail);
   modport slave  (input  in_data, in_valid, in_sync, exp_sig,
                   output busy, done, pass, timeout, signature, frames_ok, frames_fail);
endinterface

// File: rtl/bist_misr.sv
// bist_misr: MISR register with seed-load and shift controls
// clk/rst: clock, sync active-high reset (clears to 0)
// load_seed: m <= step(MISR_SEED, d); shift: m <= step(m, d)
// m: current register; nxt: value the register would take this cycle
module bist_misr import bist_pkg::*; #(
   parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
   parameter logic [DATA_WIDTH-1:0] MISR_POLY  = DATA_WIDTH'(DEF_MISR_POLY),
   parameter logic [DATA_WIDTH-1:0] MISR_SEED  = DATA_WIDTH'(DEF_MISR_SEED)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_seed,
   input  logic                  shift,
   input  logic [DATA_WIDTH-1:0] d,
   output logic [DATA_WIDTH-1:0] m,
   output logic [DATA_WIDTH-1:0] nxt
);
   assign nxt = DATA_WIDTH'(misr_step(wide_t'(load_seed ? MISR_SEED : m), wide_t'(d),
                                      wide_t'(MISR_POLY), DATA_WIDTH));
   always_ff @(posedge clk)
      if (rst) m <= '0;
      else if (load_seed | shift) m <= nxt;
endmodule

// File: rtl/bist_sig_checker.sv
// bist_sig_checker: compacts FRAME_LEN-word frames into a MISR and checks against exp_sig
// clk/rst: clock, sync active-high reset
// bus (slave): stream in_data/in_valid/in_sync + exp_sig; busy, done pulse, held pass/timeout/signature,
//              saturating frames_ok/frames_fail tallies
module bist_sig_checker import bist_pkg::*; #(
   parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int                    FRAME_LEN  = DEF_FRAME_LEN,
   parameter logic [DATA_WIDTH-1:0] MISR_POLY  = DATA_WIDTH'(DEF_MISR_POLY),
   parameter logic [DATA_WIDTH-1:0] MISR_SEED  = DATA_WIDTH'(DEF_MISR_SEED),
   parameter int                    TIMEOUT    = DEF_TIMEOUT
) (
   input logic               clk,
   input logic               rst,
   bist_sig_checker_if.slave bus
);
   localparam int CW = $clog2(FRAME_LEN + 1);
   localparam int GW = $clog2(TIMEOUT + 1);
   state_t                state, state_n;
   logic [CW-1:0]         word_cnt;
   logic [GW-1:0]         gap_cnt;
   logic [DATA_WIDTH-1:0] misr, nxt, signature;
   logic                  start, shift, last, tmo, pass, timeout, ok;
   logic [15:0]           frames_ok, frames_fail;
   bist_misr #(.DATA_WIDTH(DATA_WIDTH), .MISR_POLY(MISR_POLY), .MISR_SEED(MISR_SEED)) u_misr (
      .clk(clk), .rst(rst), .load_seed(start), .shift(shift), .d(bus.in_data), .m(misr), .nxt(nxt));
   // a sync word restarts a frame from any state, discarding any partial frame
   always_comb begin
      start   = bus.in_valid & bus.in_sync;
      shift   = (state == COLLECT) & bus.in_valid & ~bus.in_sync;
      last    = (start & (FRAME_LEN == 1)) | (shift & (word_cnt == CW'(FRAME_LEN - 1)));
      tmo     = (state == COLLECT) & ~bus.in_valid & (gap_cnt == GW'(TIMEOUT - 1));
      ok      = nxt == bus.exp_sig;
      state_n = (last | tmo) ? REPORT : (start | (state == COLLECT)) ? COLLECT : IDLE;
   end
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= state_n;
   always_ff @(posedge clk)
      if (rst) begin
         word_cnt    <= '0;
         gap_cnt     <= '0;
         signature   <= '0;
         pass        <= 1'b0;
         timeout     <= 1'b0;
         frames_ok   <= '0;
         frames_fail <= '0;
      end else begin
         if (start) begin
            word_cnt <= CW'(1);
            gap_cnt  <= '0;
         end else if (shift) begin
            word_cnt <= word_cnt + CW'(1);
            gap_cnt  <= '0;
         end else if (state == COLLECT) gap_cnt <= gap_cnt + GW'(1);
         if (last) begin
            signature <= nxt;
            pass      <= ok;
            timeout   <= 1'b0;
            if (ok && frames_ok != 16'hFFFF) frames_ok <= frames_ok + 16'd1;
            if (!ok && frames_fail != 16'hFFFF) frames_fail <= frames_fail + 16'd1;
         end else if (tmo) begin
            signature <= misr;
            pass      <= 1'b0;
            timeout   <= 1'b1;
            if (frames_fail != 16'hFFFF) frames_fail <= frames_fail + 16'd1;
         end
      end
   assign bus.busy        = state == COLLECT;
   assign bus.done        = state == REPORT;
   assign bus.pass        = pass;
   assign bus.timeout     = timeout;
   assign bus.signature   = signature;
   assign bus.frames_ok   = frames_ok;
   assign bus.frames_fail = frames_fail;
endmodule

// File: tb/tb_bist_sig_checker.sv
// tb_bist_sig_checker: directed vectors against four parameterisations of bist_sig_checker
module tb_bist_sig_checker;
   logic        clk = 1'b0;
   logic        rst, v, s;
   logic [31:0] d, e;
   int          sel, checks = 0, failures = 0, n;
   bist_sig_checker_if b[4] ();
   for (genvar k = 0; k < 4; k++) begin : g_drv
      assign b[k].in_data  = d;
      assign b[k].in_valid = v && (sel == k);
      assign b[k].in_sync  = s;
      assign b[k].exp_sig  = e;
   end
   bist_sig_checker #(.FRAME_LEN(1), .MISR_SEED(32'h0)) u0 (.clk(clk), .rst(rst), .bus(b[0]));
   bist_sig_checker #(.FRAME_LEN(2), .MISR_SEED(32'h0)) u1 (.clk(clk), .rst(rst), .bus(b[1]));
   bist_sig_checker #(.FRAME_LEN(4), .TIMEOUT(3), .MISR_SEED(32'h0)) u2 (.clk(clk), .rst(rst), .bus(b[2]));
   bist_sig_checker #(.FRAME_LEN(1)) u3 (.clk(clk), .rst(rst), .bus(b[3]));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic put(input int k, input logic sy, input logic [31:0] w, input logic [31:0] ex);
      sel = k; v = 1'b1; s = sy; d = w; e = ex;
      tick();
   endtask
   task automatic idle();
      v = 1'b0; s = 1'b0;
      tick();
   endtask
   initial begin
      rst = 1'b1; v = 1'b0; s = 1'b0; d = '0; e = '0; sel = 0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_done", 32'(b[0].done), 0);
      chk("rst_busy", 32'(b[0].busy), 0);
      chk("rst_sig", b[0].signature, 0);
      chk("rst_ok", 32'(b[0].frames_ok), 0);
      // single-word frame
      put(0, 1, 32'hA5A5A5A5, 32'hA5A5A5A5);
      chk("fl1_done", 32'(b[0].done), 1);
      chk("fl1_pass", 32'(b[0].pass), 1);
      chk("fl1_sig", b[0].signature, 32'hA5A5A5A5);
      chk("fl1_ok", 32'(b[0].frames_ok), 1);
      idle();
      chk("fl1_done_low", 32'(b[0].done), 0);
      chk("fl1_pass_held", 32'(b[0].pass), 1);
      // two-word frame, matching then mismatching expectation
      put(1, 1, 32'h80000000, 0);
      chk("fl2_busy", 32'(b[1].busy), 1);
      chk("fl2_early_done", 32'(b[1].done), 0);
      put(1, 0, 32'h0, 32'h04C11DB7);
      chk("fl2_done", 32'(b[1].done), 1);
      chk("fl2_pass", 32'(b[1].pass), 1);
      chk("fl2_sig", b[1].signature, 32'h04C11DB7);
      idle();
      put(1, 1, 32'h80000000, 0);
      put(1, 0, 32'h0, 32'h0);
      chk("fl2b_pass", 32'(b[1].pass), 0);
      chk("fl2b_fail", 32'(b[1].frames_fail), 1);
      chk("fl2b_ok", 32'(b[1].frames_ok), 1);
      idle();
      // gap timeout after two words
      put(2, 1, 32'h1, 0);
      put(2, 0, 32'h10, 0);
      idle();
      chk("to_gap1", 32'(b[2].done), 0);
      idle();
      chk("to_gap2", 32'(b[2].done), 0);
      idle();
      chk("to_done", 32'(b[2].done), 1);
      chk("to_flag", 32'(b[2].timeout), 1);
      chk("to_pass", 32'(b[2].pass), 0);
      chk("to_sig", b[2].signature, 32'h12);
      chk("to_fail", 32'(b[2].frames_fail), 1);
      idle();
      chk("to_idle_busy", 32'(b[2].busy), 0);
      // resync mid-frame; only the restarted frame counts
      n = 0;
      put(2, 1, 32'hFF, 0); n += int'(b[2].done);
      put(2, 0, 32'h1, 0);  n += int'(b[2].done);
      put(2, 1, 32'h1, 0);  n += int'(b[2].done);
      put(2, 0, 32'h2, 0);  n += int'(b[2].done);
      put(2, 0, 32'h3, 0);  n += int'(b[2].done);
      put(2, 0, 32'h4, 32'h2); n += int'(b[2].done);
      chk("rs_dones", 32'(n), 1);
      chk("rs_sig", b[2].signature, 32'h2);
      chk("rs_pass", 32'(b[2].pass), 1);
      chk("rs_timeout_clr", 32'(b[2].timeout), 0);
      chk("rs_ok", 32'(b[2].frames_ok), 1);
      // back-to-back: new sync word during REPORT
      put(2, 1, 32'h80000000, 0);
      chk("bb_busy", 32'(b[2].busy), 1);
      chk("bb_done_low", 32'(b[2].done), 0);
      put(2, 0, 32'h0, 0);
      put(2, 0, 32'h0, 0);
      put(2, 0, 32'h0, 32'h130476DC);
      chk("bb_done", 32'(b[2].done), 1);
      chk("bb_sig", b[2].signature, 32'h130476DC);
      chk("bb_ok", 32'(b[2].frames_ok), 2);
      idle();
      // default seed, single-word frame
      put(3, 1, 32'h0, 32'hFB3EE249);
      chk("seed_sig", b[3].signature, 32'hFB3EE249);
      chk("seed_pass", 32'(b[3].pass), 1);
      idle();
      // reset mid-collect
      put(2, 1, 32'h5, 0);
      put(2, 0, 32'h6, 0);
      chk("mr_busy", 32'(b[2].busy), 1);
      v = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mr_busy0", 32'(b[2].busy), 0);
      chk("mr_done0", 32'(b[2].done), 0);
      chk("mr_sig0", b[2].signature, 0);
      chk("mr_ok0", 32'(b[2].frames_ok), 0);
      chk("mr_fail0", 32'(b[2].frames_fail), 0);
      n = 0;
      for (int i = 0; i < 5; i++) begin
         put(2, 0, 32'h7 + 32'(i), 0);
         n += int'(b[2].busy) + int'(b[2].done);
      end
      chk("mr_nosync_ignored", 32'(n), 0);
      idle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
